// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - access-size and FSM types plus byte-enable helper for the data memory
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << lane;
         SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - store lane replication/byte-enables and load lane extraction/extension
module mem_lane_fmt
   import mips_mem_pkg::*;
(
   input  mem_size_t   st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_data,
   output logic [3:0]  st_be,
   input  mem_size_t   ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be = lane_mask(st_size, st_lane);
      // replicate so the byte-enables alone select the destination lanes
      case (st_size)
         SZ_BYTE: st_data = {4{st_wdata[7:0]}};
         SZ_HALF: st_data = {2{st_wdata[15:0]}};
         default: st_data = st_wdata;
      endcase
   end

   always_comb begin
      ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
      ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_size)
         SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
         SZ_WORD: ld_data = ld_word;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_bytelane.sv
// rtl/data_mem_bytelane.sv - MIPS data memory with sized loads/stores, handshake and read latency
module data_mem_bytelane
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     rsp_valid,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [31:0]              dbg_rdata
);

   localparam int IDX_W = $clog2(DEPTH);

   dmem_state_t       state;
   logic [1:0]        cnt;
   logic [31:0]       mem [DEPTH];

   mem_size_t         lat_size;
   logic [1:0]        lat_lane;
   logic              lat_uns;
   logic [IDX_W-1:0]  lat_idx;

   mem_size_t         req_sz;
   logic [ADDR_W-3:0] req_widx;
   logic [IDX_W-1:0]  req_idx;
   logic              req_err;
   logic              accept;

   mem_size_t         ld_size;
   logic [1:0]        ld_lane;
   logic              ld_uns;
   logic [IDX_W-1:0]  ld_idx;
   logic [31:0]       ld_data;
   logic [31:0]       st_data;
   logic [3:0]        st_be;

   assign req_sz    = mem_size_t'(req_size);
   assign req_widx  = req_addr[ADDR_W-1:2];
   assign req_idx   = req_widx[IDX_W-1:0];
   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      case (req_sz)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if (req_widx >= (ADDR_W-2)'(DEPTH))
         req_err = 1'b1;
   end

   // an RD_LAT==1 load formats from the live request; longer loads use the latched copy
   assign ld_size = (state == IDLE) ? req_sz           : lat_size;
   assign ld_lane = (state == IDLE) ? req_addr[1:0]    : lat_lane;
   assign ld_uns  = (state == IDLE) ? req_unsigned     : lat_uns;
   assign ld_idx  = (state == IDLE) ? req_idx          : lat_idx;

   mem_lane_fmt u_fmt (
      .st_size     (req_sz),
      .st_lane     (req_addr[1:0]),
      .st_wdata    (req_wdata),
      .st_data     (st_data),
      .st_be       (st_be),
      .ld_size     (ld_size),
      .ld_lane     (ld_lane),
      .ld_unsigned (ld_uns),
      .ld_word     (mem[ld_idx]),
      .ld_data     (ld_data)
   );

   generate
      if ((1 << IDX_W) > DEPTH) begin : g_dbg_guard
         assign dbg_rdata = (32'(dbg_addr) < 32'(DEPTH)) ? mem[dbg_addr] : 32'h0;
      end else begin : g_dbg_direct
         assign dbg_rdata = mem[dbg_addr];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         lat_size  <= SZ_BYTE;
         lat_lane  <= '0;
         lat_uns   <= 1'b0;
         lat_idx   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         // response fields are pulses; they fall back to zero outside RESP
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_size <= req_sz;
                  lat_lane <= req_addr[1:0];
                  lat_uns  <= req_unsigned;
                  lat_idx  <= req_idx;
                  cnt      <= '0;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we) begin
                     for (int k = 0; k < 4; k++)
                        if (st_be[k])
                           mem[req_idx][8*k +: 8] <= st_data[8*k +: 8];
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else if (RD_LAT > 1) begin
                     state <= WAIT;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= ld_data;
                  end
               end
            end
            WAIT: begin
               if (cnt == 2'(RD_LAT - 2)) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ld_data;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
